knn_topk_stream: RTL and testbench

Streaming K-nearest-neighbour engine for the point-grouping pipeline, parametrised in point count, coordinate width and K. It accepts one centre point (CP), then DN local points (LP), each with a per-point enable bit. It returns the K closest enabled points as a distance-sorted list of coordinates, squared distances and point indices. It supersedes the fixed K=3 KNN top level and adds arbitrary K, index output, partial-result count and an optional radius filter.

---
 rtl/knn_pkg.sv | 47 ++++
 rtl/knn_topk_stream_if.sv | 42 ++++
 rtl/knn_dist_sq.sv | 72 +++++++
 rtl/knn_topk_stream.sv | 237 +++++++++++++++++++++++
 tb/tb_knn_topk_stream.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/knn_pkg.sv
// knn_pkg: shared types and helpers for the streaming top-K nearest-neighbour engine.
//   - state_t         : FSM states of knn_topk_stream
//   - dist_w / idx_w / cnt_w : width derivations (squared distance, point index, slot count)
//   - get_x/get_y/get_z      : axis extraction from a packed {x,y,z} point word (x at MSBs)
//   - DIST_INF        : all-ones distance used for empty list slots
// Helpers work on words up to CW_MAX bits per axis; callers cast to their own widths.
package knn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        OUT    = 2'd3
    } state_t;

    localparam int CW_MAX = 16;
    localparam int PW_MAX = 3 * CW_MAX;
    localparam int DW_MAX = 2 * CW_MAX + 2;

    localparam logic [DW_MAX-1:0] DIST_INF = '1;

    // Three squares of CW-bit values need two extra bits on top of 2*CW.
    function automatic int dist_w(input int cw);
        return 2 * cw + 2;
    endfunction

    function automatic int idx_w(input int dn);
        return (dn > 1) ? $clog2(dn) : 1;
    endfunction

    function automatic int cnt_w(input int k);
        return $clog2(k + 1);
    endfunction

    function automatic logic [CW_MAX-1:0] get_x(input logic [PW_MAX-1:0] pt, input int cw);
        return CW_MAX'(pt >> (2 * cw)) & ~({CW_MAX{1'b1}} << cw);
    endfunction

    function automatic logic [CW_MAX-1:0] get_y(input logic [PW_MAX-1:0] pt, input int cw);
        return CW_MAX'(pt >> cw) & ~({CW_MAX{1'b1}} << cw);
    endfunction

    function automatic logic [CW_MAX-1:0] get_z(input logic [PW_MAX-1:0] pt, input int cw);
        return CW_MAX'(pt) & ~({CW_MAX{1'b1}} << cw);
    endfunction

endpackage

// File: rtl/knn_topk_stream_if.sv
// knn_topk_stream_if: handshake bundle of the top-K engine.
//   centre point : cp, cp_vld -> / <- cp_ready
//   local points : lp, lp_en, lp_vld -> / <- lp_ready
//   result       : <- out_pt, out_dist, out_idx, out_cnt, out_vld / out_ready ->
//   status       : <- busy
// master = point source / result sink, slave = knn_topk_stream.
interface knn_topk_stream_if #(
    parameter int DN = 1024,
    parameter int CW = 8,
    parameter int K  = 3
);
    localparam int PW  = 3 * CW;
    localparam int DW  = 2 * CW + 2;
    localparam int IW  = (DN > 1) ? $clog2(DN) : 1;
    localparam int CNW = $clog2(K + 1);

    logic [PW-1:0]     cp;
    logic              cp_vld;
    logic              cp_ready;
    logic [PW-1:0]     lp;
    logic              lp_en;
    logic              lp_vld;
    logic              lp_ready;
    logic [K*PW-1:0]   out_pt;
    logic [K*DW-1:0]   out_dist;
    logic [K*IW-1:0]   out_idx;
    logic [CNW-1:0]    out_cnt;
    logic              out_vld;
    logic              out_ready;
    logic              busy;

    modport master (
        output cp, cp_vld, lp, lp_en, lp_vld, out_ready,
        input  cp_ready, lp_ready, out_pt, out_dist, out_idx, out_cnt, out_vld, busy
    );

    modport slave (
        input  cp, cp_vld, lp, lp_en, lp_vld, out_ready,
        output cp_ready, lp_ready, out_pt, out_dist, out_idx, out_cnt, out_vld, busy
    );

endinterface

// File: rtl/knn_dist_sq.sv
// knn_dist_sq: two-stage squared Euclidean distance between a held centre point and
// a stream of local points.
//   clk, rst_n            : clock, asynchronous active-low reset (clears valids only)
//   cp                    : centre point, stable for the whole pass
//   lp_p0/en_p0/idx_p0/vld_p0 : captured local point with its enable and index
//   vld_p1                : stage-1 occupancy, lets the caller see the pipe drain
//   dist_p2/lp_p2/en_p2/idx_p2/vld_p2 : distance with the point and sideband aligned
module knn_dist_sq
    import knn_pkg::*;
#(
    parameter int CW = 8,
    parameter int IW = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3*CW-1:0]    cp,
    input  logic [3*CW-1:0]    lp_p0,
    input  logic               en_p0,
    input  logic [IW-1:0]      idx_p0,
    input  logic               vld_p0,
    output logic               vld_p1,
    output logic [2*CW+1:0]    dist_p2,
    output logic [3*CW-1:0]    lp_p2,
    output logic               en_p2,
    output logic [IW-1:0]      idx_p2,
    output logic               vld_p2
);
    localparam int PW = 3 * CW;
    localparam int DW = dist_w(CW);

    logic [CW-1:0] dx_p1, dy_p1, dz_p1;
    logic [PW-1:0] lp_p1;
    logic          en_p1;
    logic [IW-1:0] idx_p1;

    function automatic logic [CW-1:0] absdiff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [DW-1:0] sq(input logic [CW-1:0] a);
        return DW'(a) * DW'(a);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // p0 -> p1: per-axis absolute differences
    always_ff @(posedge clk) begin
        dx_p1  <= absdiff(CW'(get_x(PW_MAX'(cp), CW)), CW'(get_x(PW_MAX'(lp_p0), CW)));
        dy_p1  <= absdiff(CW'(get_y(PW_MAX'(cp), CW)), CW'(get_y(PW_MAX'(lp_p0), CW)));
        dz_p1  <= absdiff(CW'(get_z(PW_MAX'(cp), CW)), CW'(get_z(PW_MAX'(lp_p0), CW)));
        lp_p1  <= lp_p0;
        en_p1  <= en_p0;
        idx_p1 <= idx_p0;
    end

    // p1 -> p2: sum of squares, exact in DW bits
    always_ff @(posedge clk) begin
        dist_p2 <= sq(dx_p1) + sq(dy_p1) + sq(dz_p1);
        lp_p2   <= lp_p1;
        en_p2   <= en_p1;
        idx_p2  <= idx_p1;
    end

endmodule

// File: rtl/knn_topk_stream.sv
// knn_topk_stream: streaming K-nearest-neighbour engine. Takes one centre point, then
// DN local points, and returns the K closest enabled points sorted by squared distance.
//   clk, rst_n : clock, asynchronous active-low reset
//   radius_sq  : squared search radius, latched with cp (only when KNN_RADIUS_EN is defined)
//   bus        : knn_topk_stream_if slave (cp/lp handshakes, result, busy)
// Optional feature macro: KNN_RADIUS_EN -- also reject points farther than radius_sq.
module knn_topk_stream
    import knn_pkg::*;
#(
    parameter int DN = 1024,
    parameter int CW = 8,
    parameter int K  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef KNN_RADIUS_EN
    input  logic [2*CW+1:0]    radius_sq,
`endif
    knn_topk_stream_if.slave   bus
);
    localparam int PW  = 3 * CW;
    localparam int DW  = dist_w(CW);
    localparam int IW  = idx_w(DN);
    localparam int CNW = cnt_w(K);

    state_t         state;
    logic           cp_rdy, lp_rdy, out_v, busy_r;
    logic [IW-1:0]  lp_cnt;
    logic [PW-1:0]  cp_q;
`ifdef KNN_RADIUS_EN
    logic [DW-1:0]  radius_q;
`endif

    logic           cp_hs, lp_hs;

    logic [PW-1:0]  lp_p0;
    logic           en_p0, vld_p0, vld_p1;
    logic [IW-1:0]  idx_p0;
    logic [DW-1:0]  dist_p2;
    logic [PW-1:0]  lp_p2;
    logic           en_p2, vld_p2;
    logic [IW-1:0]  idx_p2;

    // Sorted list: slot 0 nearest, valid slots always contiguous from slot 0.
    logic [DW-1:0]  slot_dist [K];
    logic [PW-1:0]  slot_pt   [K];
    logic [IW-1:0]  slot_idx  [K];
    logic [K-1:0]   slot_ok;
    logic [CNW-1:0] cnt;

    logic           in_rad, ins;
    logic [K-1:0]   le, le_prev;
    logic [DW-1:0]  prev_dist [K];
    logic [PW-1:0]  prev_pt   [K];
    logic [IW-1:0]  prev_idx  [K];
    logic [K-1:0]   prev_ok;

    assign cp_hs = cp_rdy & bus.cp_vld;
    assign lp_hs = lp_rdy & bus.lp_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cp_rdy <= 1'b1;
            lp_rdy <= 1'b0;
            out_v  <= 1'b0;
            busy_r <= 1'b0;
            lp_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cp_hs) begin
                        state  <= STREAM;
                        cp_rdy <= 1'b0;
                        lp_rdy <= 1'b1;
                        busy_r <= 1'b1;
                        lp_cnt <= '0;
                    end
                end
                STREAM: begin
                    if (lp_hs) begin
                        lp_cnt <= lp_cnt + 1'b1;
                        if (lp_cnt == IW'(DN - 1)) begin
                            state  <= DRAIN;
                            lp_rdy <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // Leave on the edge that retires the last point into the list.
                    if (!vld_p0 && !vld_p1) begin
                        state <= OUT;
                        out_v <= 1'b1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state  <= IDLE;
                        out_v  <= 1'b0;
                        cp_rdy <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cp_hs) begin
            cp_q <= bus.cp;
`ifdef KNN_RADIUS_EN
            radius_q <= radius_sq;
`endif
        end
    end

    // handshake -> p0: capture the accepted local point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p0 <= 1'b0;
        else        vld_p0 <= lp_hs;
    end

    always_ff @(posedge clk) begin
        if (lp_hs) begin
            lp_p0  <= bus.lp;
            en_p0  <= bus.lp_en;
            idx_p0 <= lp_cnt;
        end
    end

    knn_dist_sq #(.CW(CW), .IW(IW)) u_dist (
        .clk     (clk),
        .rst_n   (rst_n),
        .cp      (cp_q),
        .lp_p0   (lp_p0),
        .en_p0   (en_p0),
        .idx_p0  (idx_p0),
        .vld_p0  (vld_p0),
        .vld_p1  (vld_p1),
        .dist_p2 (dist_p2),
        .lp_p2   (lp_p2),
        .en_p2   (en_p2),
        .idx_p2  (idx_p2),
        .vld_p2  (vld_p2)
    );

`ifdef KNN_RADIUS_EN
    assign in_rad = (dist_p2 <= radius_q);
`else
    assign in_rad = 1'b1;
`endif
    assign ins = vld_p2 & en_p2 & in_rad;

    // le[s]: slot s stays ahead of the new point (<= keeps earlier index ahead on ties).
    always_comb begin
        le       = '0;
        le_prev  = '1;
        prev_ok  = '0;
        for (int s = 0; s < K; s++) begin
            le[s]        = slot_ok[s] && (slot_dist[s] <= dist_p2);
            prev_dist[s] = DW'(DIST_INF);
            prev_pt[s]   = '0;
            prev_idx[s]  = '0;
        end
        for (int s = 1; s < K; s++) begin
            le_prev[s]   = le[s-1];
            prev_dist[s] = slot_dist[s-1];
            prev_pt[s]   = slot_pt[s-1];
            prev_idx[s]  = slot_idx[s-1];
            prev_ok[s]   = slot_ok[s-1];
        end
    end

    // p2 -> list: one compare/shift/insert per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < K; s++) begin
                slot_dist[s] <= DW'(DIST_INF);
                slot_pt[s]   <= '0;
                slot_idx[s]  <= '0;
            end
            slot_ok <= '0;
            cnt     <= '0;
        end else if (cp_hs) begin
            for (int s = 0; s < K; s++) begin
                slot_dist[s] <= DW'(DIST_INF);
                slot_pt[s]   <= '0;
                slot_idx[s]  <= '0;
            end
            slot_ok <= '0;
            cnt     <= '0;
        end else if (ins && !le[K-1]) begin
            for (int s = 0; s < K; s++) begin
                if (!le[s]) begin
                    if (le_prev[s]) begin
                        slot_dist[s] <= dist_p2;
                        slot_pt[s]   <= lp_p2;
                        slot_idx[s]  <= idx_p2;
                        slot_ok[s]   <= 1'b1;
                    end else begin
                        slot_dist[s] <= prev_dist[s];
                        slot_pt[s]   <= prev_pt[s];
                        slot_idx[s]  <= prev_idx[s];
                        slot_ok[s]   <= prev_ok[s];
                    end
                end
            end
            if (cnt != CNW'(K)) cnt <= cnt + 1'b1;
        end
    end

    logic [K*PW-1:0] out_pt_w;
    logic [K*DW-1:0] out_dist_w;
    logic [K*IW-1:0] out_idx_w;

    always_comb begin
        out_pt_w   = '0;
        out_dist_w = '0;
        out_idx_w  = '0;
        for (int s = 0; s < K; s++) begin
            out_pt_w[s*PW +: PW]   = slot_pt[s];
            out_dist_w[s*DW +: DW] = slot_dist[s];
            out_idx_w[s*IW +: IW]  = slot_idx[s];
        end
    end

    assign bus.cp_ready = cp_rdy;
    assign bus.lp_ready = lp_rdy;
    assign bus.out_vld  = out_v;
    assign bus.busy     = busy_r;
    assign bus.out_pt   = out_pt_w;
    assign bus.out_dist = out_dist_w;
    assign bus.out_idx  = out_idx_w;
    assign bus.out_cnt  = cnt;

endmodule

// File: tb/tb_knn_topk_stream.sv
// tb_knn_topk_stream: directed self-checking bench for knn_topk_stream (DN=8, K=3, CW=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_knn_topk_stream;
    localparam int DN  = 8;
    localparam int CW  = 8;
    localparam int K   = 3;
    localparam int PW  = 24;
    localparam int DW  = 18;
    localparam int IW  = 3;
    localparam int CNW = 2;
    localparam logic [DW-1:0] INF = {DW{1'b1}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef KNN_RADIUS_EN
    logic [DW-1:0] radius_sq = '0;
`endif

    knn_topk_stream_if #(.DN(DN), .CW(CW), .K(K)) bus ();

    knn_topk_stream #(.DN(DN), .CW(CW), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef KNN_RADIUS_EN
        .radius_sq (radius_sq),
`endif
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] vec_pt [DN];
    logic          vec_en [DN];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_linear(input bit rev);
        for (int i = 0; i < DN; i++) begin
            vec_pt[i] = {(rev ? 8'(DN - 1 - i) : 8'(i)), 16'd0};
            vec_en[i] = 1'b1;
        end
    endtask

    // Runs CP + n_lp local points; reports handshake success and edges until out_vld.
    task automatic drive_pass(input logic [PW-1:0] c, input bit bubbles, input int n_lp,
                              output bit ok, output int lat);
        int n;
        ok  = 1'b1;
        lat = -1;
        @(negedge clk);
        bus.cp = c;
        bus.cp_vld = 1'b1;
        n = 0;
        while (!bus.cp_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.cp_ready) ok = 1'b0;
        @(negedge clk);
        bus.cp_vld = 1'b0;
        for (int i = 0; i < n_lp; i++) begin
            if (bubbles) begin
                bus.lp_vld = 1'b0;
                @(negedge clk);
            end
            bus.lp = vec_pt[i];
            bus.lp_en = vec_en[i];
            bus.lp_vld = 1'b1;
            n = 0;
            while (!bus.lp_ready && n < 20) begin @(negedge clk); n++; end
            if (!bus.lp_ready) ok = 1'b0;
            @(negedge clk);
        end
        bus.lp_vld = 1'b0;
        if (n_lp == DN) begin
            n = 0;
            while (!bus.out_vld && n < 20) begin @(negedge clk); n++; end
            if (!bus.out_vld) ok = 1'b0;
            lat = n;
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.cp_ready !== 1'b1) begin errors++; $display("FAIL reset_cp_ready: got %b want 1", bus.cp_ready); end
        checks++; if (bus.lp_ready !== 1'b0) begin errors++; $display("FAIL reset_lp_ready: got %b want 0", bus.lp_ready); end
        checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %b want 0", bus.out_vld); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.out_pt !== '0) begin errors++; $display("FAIL reset_out_pt: got %h want 0", bus.out_pt); end
        checks++; if (bus.out_dist !== {INF, INF, INF}) begin errors++; $display("FAIL reset_out_dist: got %h want all-ones", bus.out_dist); end
        checks++; if (bus.out_idx !== '0) begin errors++; $display("FAIL reset_out_idx: got %h want 0", bus.out_idx); end
        checks++; if (bus.out_cnt !== '0) begin errors++; $display("FAIL reset_out_cnt: got %0d want 0", bus.out_cnt); end
    endtask

    task automatic test_all_enabled();
        bit ok; int lat;
        set_linear(1'b0);
        drive_pass(24'h000000, 1'b0, DN, ok, lat);
        checks++; if (!ok) begin errors++; $display("FAIL all_en_handshake: got timeout want completion"); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL all_en_latency: got %0d want 3", lat); end
        checks++; if (bus.out_dist !== {18'd4, 18'd1, 18'd0}) begin errors++; $display("FAIL all_en_dist: got %h want %h", bus.out_dist, {18'd4, 18'd1, 18'd0}); end
        checks++; if (bus.out_idx !== {3'd2, 3'd1, 3'd0}) begin errors++; $display("FAIL all_en_idx: got %h want %h", bus.out_idx, {3'd2, 3'd1, 3'd0}); end
        checks++; if (bus.out_pt !== {24'h020000, 24'h010000, 24'h000000}) begin errors++; $display("FAIL all_en_pt: got %h want 020000010000000000", bus.out_pt); end
        checks++; if (bus.out_cnt !== 2'd3) begin errors++; $display("FAIL all_en_cnt: got %0d want 3", bus.out_cnt); end
        checks++; if (bus.busy !== 1'b1 || bus.cp_ready !== 1'b0) begin errors++; $display("FAIL all_en_status: got busy=%b cp_ready=%b want 1/0", bus.busy, bus.cp_ready); end
        release_out();
        checks++; if (bus.cp_ready !== 1'b1 || bus.out_vld !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL all_en_release: got cp_ready=%b out_vld=%b busy=%b want 1/0/0", bus.cp_ready, bus.out_vld, bus.busy);
        end
    endtask

    task automatic test_masking();
        bit ok; int lat;
        set_linear(1'b0);
        for (int i = 0; i < DN; i++) vec_en[i] = (i == 5 || i == 7);
        drive_pass(24'h000000, 1'b0, DN, ok, lat);
        checks++; if (!ok) begin errors++; $display("FAIL mask_handshake: got timeout want completion"); end
        checks++; if (bus.out_dist !== {INF, 18'd49, 18'd25}) begin errors++; $display("FAIL mask_dist: got %h want %h", bus.out_dist, {INF, 18'd49, 18'd25}); end
        checks++; if (bus.out_idx !== {3'd0, 3'd7, 3'd5}) begin errors++; $display("FAIL mask_idx: got %h want %h", bus.out_idx, {3'd0, 3'd7, 3'd5}); end
        checks++; if (bus.out_pt !== {24'h000000, 24'h070000, 24'h050000}) begin errors++; $display("FAIL mask_pt: got %h want 000000070000050000", bus.out_pt); end
        checks++; if (bus.out_cnt !== 2'd2) begin errors++; $display("FAIL mask_cnt: got %0d want 2", bus.out_cnt); end
        release_out();
    endtask

    task automatic test_ties();
        bit ok; int lat;
        for (int i = 0; i < DN; i++) begin vec_pt[i] = 24'h010101; vec_en[i] = 1'b1; end
        drive_pass(24'h000000, 1'b0, DN, ok, lat);
        checks++; if (!ok) begin errors++; $display("FAIL ties_handshake: got timeout want completion"); end
        checks++; if (bus.out_dist !== {18'd3, 18'd3, 18'd3}) begin errors++; $display("FAIL ties_dist: got %h want %h", bus.out_dist, {18'd3, 18'd3, 18'd3}); end
        checks++; if (bus.out_idx !== {3'd2, 3'd1, 3'd0}) begin errors++; $display("FAIL ties_idx: got %h want %h", bus.out_idx, {3'd2, 3'd1, 3'd0}); end
        checks++; if (bus.out_cnt !== 2'd3) begin errors++; $display("FAIL ties_cnt: got %0d want 3", bus.out_cnt); end
        release_out();
    endtask

    task automatic test_reverse();
        bit ok; int lat;
        set_linear(1'b1);
        drive_pass(24'h000000, 1'b0, DN, ok, lat);
        checks++; if (!ok) begin errors++; $display("FAIL reverse_handshake: got timeout want completion"); end
        checks++; if (bus.out_dist !== {18'd4, 18'd1, 18'd0}) begin errors++; $display("FAIL reverse_dist: got %h want %h", bus.out_dist, {18'd4, 18'd1, 18'd0}); end
        checks++; if (bus.out_idx !== {3'd5, 3'd6, 3'd7}) begin errors++; $display("FAIL reverse_idx: got %h want %h", bus.out_idx, {3'd5, 3'd6, 3'd7}); end
        release_out();
    endtask

    task automatic test_width_corner();
        bit ok; int lat;
        for (int i = 0; i < DN; i++) begin vec_pt[i] = 24'h000000; vec_en[i] = 1'b0; end
        vec_pt[4] = 24'hFFFFFF;
        vec_en[4] = 1'b1;
        drive_pass(24'h000000, 1'b0, DN, ok, lat);
        checks++; if (!ok) begin errors++; $display("FAIL corner_handshake: got timeout want completion"); end
        checks++; if (bus.out_dist !== {INF, INF, 18'd195075}) begin errors++; $display("FAIL corner_dist: got %h want %h", bus.out_dist, {INF, INF, 18'd195075}); end
        checks++; if (bus.out_idx !== {3'd0, 3'd0, 3'd4}) begin errors++; $display("FAIL corner_idx: got %h want %h", bus.out_idx, {3'd0, 3'd0, 3'd4}); end
        checks++; if (bus.out_pt !== {24'h000000, 24'h000000, 24'hFFFFFF}) begin errors++; $display("FAIL corner_pt: got %h want 000000000000ffffff", bus.out_pt); end
        checks++; if (bus.out_cnt !== 2'd1) begin errors++; $display("FAIL corner_cnt: got %0d want 1", bus.out_cnt); end
        release_out();
    endtask

    task automatic test_bubbles();
        bit ok; int lat;
        set_linear(1'b0);
        drive_pass(24'h000000, 1'b1, DN, ok, lat);
        checks++; if (!ok) begin errors++; $display("FAIL bubbles_handshake: got timeout want completion"); end
        checks++; if (bus.out_dist !== {18'd4, 18'd1, 18'd0}) begin errors++; $display("FAIL bubbles_dist: got %h want %h", bus.out_dist, {18'd4, 18'd1, 18'd0}); end
        checks++; if (bus.out_idx !== {3'd2, 3'd1, 3'd0}) begin errors++; $display("FAIL bubbles_idx: got %h want %h", bus.out_idx, {3'd2, 3'd1, 3'd0}); end
        checks++; if (bus.out_cnt !== 2'd3) begin errors++; $display("FAIL bubbles_cnt: got %0d want 3", bus.out_cnt); end
        release_out();
    endtask

    task automatic test_out_stall();
        bit ok; int lat;
        set_linear(1'b0);
        drive_pass(24'h000000, 1'b0, DN, ok, lat);
        checks++; if (!ok) begin errors++; $display("FAIL stall_handshake: got timeout want completion"); end
        for (int c = 0; c < 10; c++) begin
            bus.cp_vld = 1'b1;
            bus.cp = 24'h123456;
            @(negedge clk);
            checks++;
            if (bus.out_vld !== 1'b1 || bus.cp_ready !== 1'b0 || bus.out_dist !== {18'd4, 18'd1, 18'd0} ||
                bus.out_idx !== {3'd2, 3'd1, 3'd0} || bus.out_cnt !== 2'd3) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got vld=%b cp_ready=%b dist=%h idx=%h cnt=%0d want 1/0/%h/%h/3",
                         c, bus.out_vld, bus.cp_ready, bus.out_dist, bus.out_idx, bus.out_cnt,
                         {18'd4, 18'd1, 18'd0}, {3'd2, 3'd1, 3'd0});
            end
        end
        bus.cp_vld = 1'b0;
        release_out();
        checks++; if (bus.cp_ready !== 1'b1 || bus.out_vld !== 1'b0) begin errors++; $display("FAIL stall_release: got cp_ready=%b out_vld=%b want 1/0", bus.cp_ready, bus.out_vld); end
    endtask

    task automatic test_reset_midpass();
        bit ok; int lat;
        set_linear(1'b0);
        drive_pass(24'h000000, 1'b0, 4, ok, lat);
        checks++; if (bus.lp_ready !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL midreset_streaming: got lp_ready=%b busy=%b want 1/1", bus.lp_ready, bus.busy); end
        rst_n = 1'b0;
        #2;
        checks++; if (bus.cp_ready !== 1'b1 || bus.lp_ready !== 1'b0 || bus.out_vld !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL midreset_ctrl: got cp_ready=%b lp_ready=%b out_vld=%b busy=%b want 1/0/0/0", bus.cp_ready, bus.lp_ready, bus.out_vld, bus.busy);
        end
        checks++; if (bus.out_pt !== '0 || bus.out_idx !== '0 || bus.out_cnt !== '0 || bus.out_dist !== {INF, INF, INF}) begin
            errors++; $display("FAIL midreset_outputs: got pt=%h dist=%h idx=%h cnt=%0d want 0/all-ones/0/0", bus.out_pt, bus.out_dist, bus.out_idx, bus.out_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (bus.cp_ready !== 1'b1 || bus.out_vld !== 1'b0 || bus.out_cnt !== '0) begin
            errors++; $display("FAIL midreset_settled: got cp_ready=%b out_vld=%b cnt=%0d want 1/0/0", bus.cp_ready, bus.out_vld, bus.out_cnt);
        end
        drive_pass(24'h000000, 1'b0, DN, ok, lat);
        checks++; if (!ok || bus.out_dist !== {18'd4, 18'd1, 18'd0} || bus.out_cnt !== 2'd3) begin
            errors++; $display("FAIL midreset_recover: got ok=%b dist=%h cnt=%0d want 1/%h/3", ok, bus.out_dist, bus.out_cnt, {18'd4, 18'd1, 18'd0});
        end
        release_out();
    endtask

`ifdef KNN_RADIUS_EN
    task automatic test_radius();
        bit ok; int lat;
        set_linear(1'b0);
        radius_sq = 18'd4;
        drive_pass(24'h000000, 1'b0, DN, ok, lat);
        radius_sq = 18'd0;
        checks++; if (!ok || bus.out_cnt !== 2'd3) begin errors++; $display("FAIL radius4_cnt: got ok=%b cnt=%0d want 1/3", ok, bus.out_cnt); end
        release_out();
        radius_sq = 18'd3;
        drive_pass(24'h000000, 1'b0, DN, ok, lat);
        radius_sq = 18'd0;
        checks++; if (!ok || bus.out_cnt !== 2'd2) begin errors++; $display("FAIL radius3_cnt: got ok=%b cnt=%0d want 1/2", ok, bus.out_cnt); end
        checks++; if (bus.out_dist !== {INF, 18'd1, 18'd0}) begin errors++; $display("FAIL radius3_dist: got %h want %h", bus.out_dist, {INF, 18'd1, 18'd0}); end
        release_out();
    endtask
`endif

    initial begin
        bus.cp = '0;
        bus.cp_vld = 1'b0;
        bus.lp = '0;
        bus.lp_en = 1'b0;
        bus.lp_vld = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_all_enabled();
        test_masking();
        test_ties();
        test_reverse();
        test_width_corner();
        test_bubbles();
        test_out_stall();
        test_reset_midpass();
`ifdef KNN_RADIUS_EN
        test_radius();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
